// File: rtl/pad_pmux_ctrl.sv
// Pad pin-mux controller: register-programmed per-pin function select with an
// isolation sequencer that holds changing pins safe before a new function is applied.
module pad_pmux_ctrl #(
   parameter int NB_PINS     = 16,
   parameter int SAFE_CYCLES = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [2:0]         reg_addr,
   input  logic               reg_wr,
   input  logic               reg_rd,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata,
   input  logic [NB_PINS-1:0] alt1_dout,
   input  logic [NB_PINS-1:0] alt1_oe,
   input  logic [NB_PINS-1:0] alt2_dout,
   input  logic [NB_PINS-1:0] alt2_oe,
   output logic [NB_PINS-1:0] pin_in_sync,
   input  logic [NB_PINS-1:0] pad_pmux_din,
   output logic [NB_PINS-1:0] pmux_pad_dout,
   output logic [NB_PINS-1:0] pmux_pad_oe,
   output logic [NB_PINS-1:0] pmux_pad_ie,
   output logic               busy
);

   localparam int FW = 2 * NB_PINS;
   localparam logic [3:0] CNT_LAST = 4'(SAFE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISOLATE = 2'd1,
      ST_APPLY   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [NB_PINS-1:0] chg_mask_q, chg_mask_d;
   logic [FW-1:0]      func_act_q, func_act_d;
   logic [FW-1:0]      func_req_q;
   logic [NB_PINS-1:0] gpio_out_q;
   logic [NB_PINS-1:0] gpio_oe_q;
   logic [NB_PINS-1:0] sync1_q, sync2_q;
   logic [31:0]        rdata_q, rdata_d;

   logic               wr_fs;
   logic [NB_PINS-1:0] req_diff;
   logic [NB_PINS-1:0] wr_diff;

   assign wr_fs = reg_wr && (reg_addr == 3'd0);

   // Per-pin comparisons against the active function, and the pad mux itself
   for (genvar gi = 0; gi < NB_PINS; gi++) begin : g_pin
      logic [1:0] code;
      logic       pin_dout, pin_oe, pin_ie;

      assign req_diff[gi] = (func_req_q[2*gi +: 2] != func_act_q[2*gi +: 2]);
      assign wr_diff[gi]  = (reg_wdata[2*gi +: 2] != func_act_q[2*gi +: 2]);
      assign code         = func_act_q[2*gi +: 2];

      always_comb begin
         pin_dout = 1'b0;
         pin_oe   = 1'b0;
         pin_ie   = 1'b0;
         if (!chg_mask_q[gi]) begin
            unique case (code)
               2'b00: begin
                  pin_dout = gpio_out_q[gi];
                  pin_oe   = gpio_oe_q[gi];
                  pin_ie   = 1'b1;
               end
               2'b01: begin
                  pin_dout = alt1_dout[gi];
                  pin_oe   = alt1_oe[gi];
                  pin_ie   = 1'b1;
               end
               2'b10: begin
                  pin_dout = alt2_dout[gi];
                  pin_oe   = alt2_oe[gi];
                  pin_ie   = 1'b1;
               end
               default: begin
                  pin_dout = 1'b0;
                  pin_oe   = 1'b0;
                  pin_ie   = 1'b0;
               end
            endcase
         end
      end

      assign pmux_pad_dout[gi] = pin_dout;
      assign pmux_pad_oe[gi]   = pin_oe;
      assign pmux_pad_ie[gi]   = pin_ie;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         chg_mask_q <= '0;
         func_act_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         chg_mask_q <= chg_mask_d;
         func_act_q <= func_act_d;
      end
   end

   // A write landing in the same IDLE cycle that starts a sequence is isolated too,
   // so APPLY never switches a pin that was not held safe.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      chg_mask_d = chg_mask_q;
      func_act_d = func_act_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_diff != '0) begin
               chg_mask_d = req_diff | (wr_fs ? wr_diff : '0);
               cnt_d      = '0;
               state_d    = ST_ISOLATE;
            end
         end
         ST_ISOLATE: begin
            if (wr_fs) begin
               chg_mask_d = chg_mask_q | wr_diff;
               cnt_d      = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_APPLY;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_APPLY: begin
            func_act_d = func_req_q;
            chg_mask_d = '0;
            cnt_d      = '0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   always_comb begin
      rdata_d = '0;
      unique case (reg_addr)
         3'd0: rdata_d[FW-1:0]        = func_req_q;
         3'd1: rdata_d[NB_PINS-1:0]   = gpio_out_q;
         3'd2: rdata_d[NB_PINS-1:0]   = gpio_oe_q;
         3'd3: rdata_d[NB_PINS-1:0]   = sync2_q;
         3'd4: begin
            rdata_d[16 +: NB_PINS] = chg_mask_q;
            rdata_d[0]             = busy;
         end
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         func_req_q <= '0;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         rdata_q    <= '0;
      end else begin
         sync1_q <= pad_pmux_din;
         sync2_q <= sync1_q;
         if (wr_fs) func_req_q <= reg_wdata[FW-1:0];
         if (reg_wr && reg_addr == 3'd1) gpio_out_q <= reg_wdata[NB_PINS-1:0];
         if (reg_wr && reg_addr == 3'd2) gpio_oe_q <= reg_wdata[NB_PINS-1:0];
         if (reg_rd) rdata_q <= rdata_d;
      end
   end

   assign reg_rdata   = rdata_q;
   assign pin_in_sync = sync2_q;

endmodule

// File: doc/pad_pmux_ctrl.md
PAD_PMUX_CTRL -- requirements
Module: pad_pmux_ctrl

Interface
REQ-001 SHALL have parameter NB_PINS, default 16, number of port A pads controlled.
REQ-002 SHALL have parameter SAFE_CYCLES, default 4, number of isolation cycles on a function change, legal range 1-15.
REQ-003 SHALL have port clk_in, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have port reg_addr, input, 3, register select.
REQ-006 SHALL have port reg_wr, input, 1, write strobe, one write per high cycle.
REQ-007 SHALL have port reg_rd, input, 1, read strobe.
REQ-008 SHALL have port reg_wdata, input, 32, write data.
REQ-009 SHALL have port reg_rdata, output, 32, read data, registered.
REQ-010 SHALL have port alt1_dout / alt1_oe, input, NB_PINS each, alternate function 1 drive and enable.
REQ-011 SHALL have port alt2_dout / alt2_oe, input, NB_PINS each, alternate function 2 drive and enable.
REQ-012 SHALL have port pin_in_sync, output, NB_PINS, synchronized pad input to all functions.
REQ-013 SHALL have port pad_pmux_din, input, NB_PINS, raw pad input.
REQ-014 SHALL have port pmux_pad_dout / pmux_pad_oe / pmux_pad_ie, output, NB_PINS each, pad controls.
REQ-015 SHALL have port busy, output, 1, function-switch sequence in progress.

Function
REQ-016 Register map SHALL be: 0 FUNC_SEL (RW, 2 bits per pin, pin i at [2i+1:2i]), 1 GPIO_OUT (RW), 2 GPIO_OE (RW), 3 GPIO_IN (RO, =pin_in_sync), 4 STATUS (RO, bit0 busy, [31:16] chg_mask); other addresses read 0; writes to RO or unmapped addresses SHALL be ignored.
REQ-017 reg_rdata SHALL be loaded in the cycle reg_rd is high, valid the next cycle, held otherwise.
REQ-018 pin_in_sync SHALL be pad_pmux_din through a 2-flop synchronizer, 2 cycles latency.
REQ-019 FUNC_SEL writes SHALL update func_req only; pad mux SHALL use func_act.
REQ-020 Per pin, func_act code 00 GPIO: dout=GPIO_OUT, oe=GPIO_OE, ie=1; 01 ALT1: alt1_dout/alt1_oe, ie=1; 10 ALT2: alt2_dout/alt2_oe, ie=1; 11 OFF: dout=0, oe=0, ie=0.
REQ-021 Any pin with chg_mask set SHALL be forced safe: dout=0, oe=0, ie=0, overriding REQ-020.
REQ-022 Pad outputs SHALL be combinational from registered state and alt inputs; a GPIO_OUT/GPIO_OE write in cycle N SHALL appear on pads in cycle N+1.
REQ-023 Sequencer states SHALL be IDLE, ISOLATE, APPLY.
REQ-024 IDLE: if func_req != func_act, chg_mask <= per-pin difference, cnt <= 0, go ISOLATE.
REQ-025 ISOLATE: cnt increments each cycle; at cnt == SAFE_CYCLES-1 go APPLY.
REQ-026 FUNC_SEL write during ISOLATE SHALL OR new per-pin differences into chg_mask and restart cnt to 0.
REQ-027 APPLY (1 cycle): func_act <= func_req value held at start of cycle; chg_mask <= 0; go IDLE.
REQ-028 FUNC_SEL write during APPLY SHALL be detected in the following IDLE cycle and start a new sequence.
REQ-029 busy SHALL be high in ISOLATE and APPLY, low in IDLE.
REQ-030 Isolated pins SHALL be safe for exactly SAFE_CYCLES+1 cycles for a single uninterrupted write; unchanged pins SHALL never glitch.

Reset
REQ-031 rst_in SHALL set func_req=func_act=0, GPIO_OUT=0, GPIO_OE=0, chg_mask=0, cnt=0, state IDLE, synchronizer flops=0, reg_rdata=0.
REQ-032 After reset all pads SHALL be GPIO input: oe=0, ie=1, dout=0; busy=0.
REQ-033 rst_in asserted during ISOLATE or APPLY SHALL abort the sequence and give REQ-031 values the next cycle.

Verification
REQ-034 Reset, read FUNC_SEL and STATUS -> 0x00000000 both; all pmux_pad_oe=0, pmux_pad_ie=all ones.
REQ-035 Write GPIO_OE=0x00FF, GPIO_OUT=0x00A5 -> next cycle pmux_pad_oe=0x00FF, pmux_pad_dout=0x00A5.
REQ-036 Write FUNC_SEL=0x00000001 (pin0 ALT1), alt1_oe[0]=1, alt1_dout[0]=1 -> pin0 oe/ie/dout=0 for 5 cycles, busy high 5 cycles, then oe=1, dout=1, ie=1; pins 1-15 unchanged throughout.
REQ-037 Write FUNC_SEL=0x1 then, 2 cycles later, 0x5 -> STATUS chg_mask=0x0003, cnt restarts, pins 0,1 safe until 5 cycles after second write, then both ALT1.
REQ-038 Drive pad_pmux_din=0x1234 -> GPIO_IN reads 0x00001234 once 2 cycles elapsed; read issued earlier returns prior value.
REQ-039 Assert rst_in during ISOLATE -> next cycle busy=0, chg_mask=0, all pins GPIO input.
